// File: rtl/fft8_engine.sv
// Iterative 8-point radix-2 DIT FFT: bit-reversed load, 12 in-place butterflies
// (one per cycle, twiddle read combinationally from an external ROM), natural-order unload.
module fft8_engine #(
   parameter int WIDTH = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [WIDTH-1:0] in_re,
   input  logic signed [WIDTH-1:0] in_im,
   output logic [1:0]              tw_addr,
   input  logic signed [WIDTH-1:0] tw_re,
   input  logic signed [WIDTH-1:0] tw_im,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [WIDTH-1:0] out_re,
   output logic signed [WIDTH-1:0] out_im,
   output logic                    out_last,
   output logic                    busy
);

   localparam int PW = 2*WIDTH+1;
   localparam logic signed [WIDTH+1:0] SAT_MAX = {3'b000, {(WIDTH-1){1'b1}}};
   localparam logic signed [WIDTH+1:0] SAT_MIN = {3'b111, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {LOAD, COMPUTE, UNLOAD} state_t;

   state_t                  state, state_nxt;
   logic [2:0]              cnt;
   logic [3:0]              step;
   logic signed [WIDTH-1:0] mem_re [8];
   logic signed [WIDTH-1:0] mem_im [8];

   logic [1:0]              stg, bfl, tw_sel;
   logic [2:0]              top, bot;
   logic signed [WIDTH-1:0] a_re, a_im, b_re, b_im;
   logic signed [PW-1:0]    prod_re, prod_im;
   logic signed [WIDTH:0]   t_re, t_im;
   logic signed [WIDTH+1:0] sum_re, sum_im, dif_re, dif_im;

   function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH+1:0] v);
      if (v > SAT_MAX)
         return SAT_MAX[WIDTH-1:0];
      else if (v < SAT_MIN)
         return SAT_MIN[WIDTH-1:0];
      else
         return v[WIDTH-1:0];
   endfunction

   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      unique case (state)
         LOAD: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid && cnt == 3'd7)
               state_nxt = COMPUTE;
         end
         COMPUTE: begin
            if (step == 4'd11)
               state_nxt = UNLOAD;
         end
         UNLOAD: begin
            out_valid = 1'b1;
            if (out_ready && cnt == 3'd7)
               state_nxt = LOAD;
         end
         default: state_nxt = LOAD;
      endcase
   end

   // Step counter splits into stage (upper bits) and butterfly (lower bits).
   assign stg = step[3:2];
   assign bfl = step[1:0];

   always_comb begin
      top    = 3'd0;
      bot    = 3'd0;
      tw_sel = 2'd0;
      case (stg)
         2'd0: begin
            top    = {bfl, 1'b0};
            bot    = {bfl, 1'b1};
            tw_sel = 2'd0;
         end
         2'd1: begin
            top    = {bfl[1], 1'b0, bfl[0]};
            bot    = {bfl[1], 1'b1, bfl[0]};
            tw_sel = {bfl[0], 1'b0};
         end
         default: begin
            top    = {1'b0, bfl};
            bot    = {1'b1, bfl};
            tw_sel = bfl;
         end
      endcase
   end

   assign tw_addr = (state == COMPUTE) ? tw_sel : 2'd0;

   assign a_re = mem_re[top];
   assign a_im = mem_im[top];
   assign b_re = mem_re[bot];
   assign b_im = mem_im[bot];

   // Full-precision complex product, floor-scaled back to Q1 and kept one bit wider
   // than a sample, since a -1.0 twiddle on a most-negative input needs it.
   assign prod_re = PW'(b_re) * PW'(tw_re) - PW'(b_im) * PW'(tw_im);
   assign prod_im = PW'(b_re) * PW'(tw_im) + PW'(b_im) * PW'(tw_re);
   assign t_re    = (WIDTH+1)'(prod_re >>> (WIDTH-1));
   assign t_im    = (WIDTH+1)'(prod_im >>> (WIDTH-1));

   assign sum_re = (WIDTH+2)'(a_re) + (WIDTH+2)'(t_re);
   assign sum_im = (WIDTH+2)'(a_im) + (WIDTH+2)'(t_im);
   assign dif_re = (WIDTH+2)'(a_re) - (WIDTH+2)'(t_re);
   assign dif_im = (WIDTH+2)'(a_im) - (WIDTH+2)'(t_im);

   assign out_re   = mem_re[cnt];
   assign out_im   = mem_im[cnt];
   assign out_last = out_valid && (cnt == 3'd7);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= LOAD;
         cnt   <= 3'd0;
         step  <= 4'd0;
         for (int i = 0; i < 8; i++) begin
            mem_re[i] <= '0;
            mem_im[i] <= '0;
         end
      end else begin
         state <= state_nxt;
         case (state)
            LOAD: begin
               if (in_valid) begin
                  mem_re[{cnt[0], cnt[1], cnt[2]}] <= in_re;
                  mem_im[{cnt[0], cnt[1], cnt[2]}] <= in_im;
                  cnt <= cnt + 3'd1;
               end
            end
            COMPUTE: begin
               mem_re[top] <= sat(sum_re >>> 1);
               mem_im[top] <= sat(sum_im >>> 1);
               mem_re[bot] <= sat(dif_re >>> 1);
               mem_im[bot] <= sat(dif_im >>> 1);
               step <= (step == 4'd11) ? 4'd0 : step + 4'd1;
            end
            UNLOAD: begin
               if (out_ready)
                  cnt <= cnt + 3'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fft8_engine.sv
// Scoreboard bench for fft8_engine: directed frames push hand-computed bins,
// a negedge monitor pops and compares on every output handshake.
module tb_fft8_engine;

   localparam int WIDTH = 16;

   logic                    clk;
   logic                    rst;
   logic                    in_valid, in_ready;
   logic signed [WIDTH-1:0] in_re, in_im;
   logic [1:0]              tw_addr;
   logic signed [WIDTH-1:0] tw_re, tw_im;
   logic                    out_valid, out_ready, out_last, busy;
   logic signed [WIDTH-1:0] out_re, out_im;

   typedef struct {
      int re;
      int im;
      int tol;
      bit last;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   int   total = 0;
   int   bad = 0;
   int   smpRe[8], smpIm[8], exRe[8], exIm[8], exTol[8];
   int   negCount = 0, lastAccept = 0, twIdx = 0, binIdx = 0, hsCount = 0;
   bit   prevValid = 0, holdPending = 0, expectLoad = 0, abort = 0;
   int   twExp[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

   fft8_engine #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_re(in_re), .in_im(in_im),
      .tw_addr(tw_addr), .tw_re(tw_re), .tw_im(tw_im),
      .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
      .out_last(out_last), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Twiddle ROM: W^k = exp(-j*2*pi*k/8) in Q1.15 (+1.0 rounds down to 32767)
   always_comb begin
      case (tw_addr)
         2'd0:    begin tw_re = 16'h7FFF; tw_im = 16'h0000; end
         2'd1:    begin tw_re = 16'h5A82; tw_im = 16'hA57E; end
         2'd2:    begin tw_re = 16'h0000; tw_im = 16'h8000; end
         default: begin tw_re = 16'hA57E; tw_im = 16'hA57E; end
      endcase
   end

   task automatic checkOutput(input string name, input int act, input int req, input int tol);
      int d;
      total++;
      d = act - req;
      if (d < 0) d = -d;
      if (d > tol) begin
         bad++;
         $display("[TB] FAIL %s: got %0d, want %0d (tol %0d)", name, act, req, tol);
      end
   endtask

   task automatic checkResetState(input string tag);
      checkOutput({tag, " in_ready"}, int'(in_ready), 1, 0);
      checkOutput({tag, " out_valid"}, int'(out_valid), 0, 0);
      checkOutput({tag, " out_last"}, int'(out_last), 0, 0);
      checkOutput({tag, " tw_addr"}, int'(tw_addr), 0, 0);
      checkOutput({tag, " busy"}, int'(busy), 0, 0);
      checkOutput({tag, " out_re"}, int'(out_re), 0, 0);
      checkOutput({tag, " out_im"}, int'(out_im), 0, 0);
   endtask

   // Sends smpRe/smpIm as one frame; optionally pushes exRe/exIm/exTol to the scoreboard,
   // inserts random idle gaps, or keeps in_valid high with junk while the engine is busy.
   task automatic applyStimulus(input bit gaps, input bit junk, input bit push);
      bit   ok;
      exp_t e;
      if (push) begin
         for (int k = 0; k < 8; k++) begin
            e.re = exRe[k];
            e.im = exIm[k];
            e.tol = exTol[k];
            e.last = (k == 7);
            sbq.push_back(e);
         end
      end
      for (int n = 0; n < 8; n++) begin
         if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
         end
         in_valid = 1'b1;
         in_re = WIDTH'(smpRe[n]);
         in_im = WIDTH'(smpIm[n]);
         ok = 1'b0;
         for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (in_ready) begin
               ok = 1'b1;
               break;
            end
            @(posedge clk);
            #1;
         end
         if (!ok) begin
            checkOutput("in_ready wait", int'(in_ready), 1, 0);
            in_valid = 1'b0;
            abort = 1'b1;
            return;
         end
         @(posedge clk);
         #1;
      end
      if (junk) begin
         for (int c = 0; c < 200; c++) begin
            in_valid = 1'b1;
            in_re = WIDTH'($urandom);
            in_im = WIDTH'($urandom);
            @(negedge clk);
            if (!busy) break;
            @(posedge clk);
            #1;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic waitDrain();
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk);
         #1;
         if (sbq.size() == 0 && !busy) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         checkOutput("frame drain", int'(busy) + sbq.size(), 0, 0);
         abort = 1'b1;
      end
   endtask

   // Monitor: scoreboard pops, stall stability, latency, twiddle addressing
   always @(negedge clk) begin
      negCount++;
      if (rst) begin
         prevValid = 1'b0;
         holdPending = 1'b0;
         expectLoad = 1'b0;
         twIdx = 0;
         binIdx = 0;
      end else begin
         if (expectLoad) begin
            checkOutput("in_ready after bin 7", int'(in_ready), 1, 0);
            checkOutput("out_valid after bin 7", int'(out_valid), 0, 0);
            expectLoad = 1'b0;
         end
         if (in_valid && in_ready)
            lastAccept = negCount;
         if (!busy)
            twIdx = 0;
         else if (!out_valid) begin
            if (twIdx < 12)
               checkOutput($sformatf("tw_addr step %0d", twIdx), int'(tw_addr), twExp[twIdx], 0);
            else
               checkOutput("compute length", twIdx, 11, 0);
            twIdx++;
         end
         if (out_valid && !prevValid) begin
            checkOutput("latency from last accept", negCount - lastAccept, 13, 0);
            checkOutput("compute cycles", twIdx, 12, 0);
         end
         if (holdPending)
            checkOutput("out_valid held", int'(out_valid), 1, 0);
         if (out_valid && !out_ready && sbq.size() > 0) begin
            checkOutput($sformatf("stalled bin%0d re", binIdx), int'(out_re), sbq[0].re, sbq[0].tol);
            checkOutput($sformatf("stalled bin%0d im", binIdx), int'(out_im), sbq[0].im, sbq[0].tol);
            checkOutput($sformatf("stalled bin%0d last", binIdx), int'(out_last), int'(sbq[0].last), 0);
         end
         if (out_valid && out_ready) begin
            checkOutput("bin expected", int'(sbq.size() > 0), 1, 0);
            if (sbq.size() > 0) begin
               cur = sbq.pop_front();
               checkOutput($sformatf("bin%0d re", binIdx), int'(out_re), cur.re, cur.tol);
               checkOutput($sformatf("bin%0d im", binIdx), int'(out_im), cur.im, cur.tol);
               checkOutput($sformatf("bin%0d last", binIdx), int'(out_last), int'(cur.last), 0);
               if (cur.last) expectLoad = 1'b1;
            end
            binIdx = (binIdx + 1) % 8;
            hsCount++;
         end
         holdPending = out_valid && !out_ready;
         prevValid = out_valid;
      end
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_re = '0;
      in_im = '0;
      out_ready = 1'b1;
      @(negedge clk);
      checkResetState("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Impulse at n=0: every bin exactly 16384/8
      smpRe = '{16384, 0, 0, 0, 0, 0, 0, 0};
      smpIm = '{default: 0};
      exRe = '{default: 2048};
      exIm = '{default: 0};
      exTol = '{default: 0};
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (!abort) waitDrain();

      // Impulse at n=1: X[k] = 2048*exp(-j*pi*k/4), exercises every twiddle
      if (!abort) begin
         smpRe = '{0, 16384, 0, 0, 0, 0, 0, 0};
         exRe = '{2048, 1448, 0, -1448, -2048, -1448, 0, 1448};
         exIm = '{0, -1448, -2048, -1448, 0, 1448, 2048, 1448};
         exTol = '{default: 2};
         applyStimulus(1'b1, 1'b0, 1'b1);
         waitDrain();
      end

      // DC, immediately followed by the cosine frame (back-to-back). Three passes through
      // the 32767 twiddle each shave up to one LSB off X[0].
      if (!abort) begin
         smpRe = '{default: 8000};
         exRe = '{8000, 0, 0, 0, 0, 0, 0, 0};
         exIm = '{default: 0};
         exTol = '{4, 1, 1, 1, 1, 1, 1, 1};
         applyStimulus(1'b0, 1'b0, 1'b1);
      end
      if (!abort) begin
         smpRe = '{16000, 11314, 0, -11314, -16000, -11314, 0, 11314};
         exRe = '{0, 8000, 0, 0, 0, 0, 0, 8000};
         exIm = '{default: 0};
         exTol = '{default: 2};
         applyStimulus(1'b0, 1'b1, 1'b1);
         waitDrain();
      end

      // Alternating full-scale input with random gaps and a 5-cycle sink stall on bin 3
      if (!abort) begin
         smpRe = '{32767, -32767, 32767, -32767, 32767, -32767, 32767, -32767};
         exRe = '{0, 0, 0, 0, 32767, 0, 0, 0};
         exIm = '{default: 0};
         exTol = '{default: 2};
         hsCount = 0;
         applyStimulus(1'b1, 1'b0, 1'b1);
      end
      if (!abort) begin
         for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            if (hsCount >= 3) break;
         end
         #1;
         checkOutput("stall point reached", hsCount, 3, 0);
         out_ready = 1'b0;
         repeat (5) @(posedge clk);
         #1;
         out_ready = 1'b1;
         waitDrain();
      end

      // Reset during the 6th COMPUTE cycle abandons the frame without output
      if (!abort) begin
         smpRe = '{0, 16384, 0, 0, 0, 0, 0, 0};
         applyStimulus(1'b0, 1'b0, 1'b0);
         repeat (5) @(posedge clk);
         #2;
         rst = 1'b1;
         @(negedge clk);
         checkResetState("mid reset");
         @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         checkResetState("after reset");
         repeat (20) @(posedge clk);
         #1;
      end

      // A clean impulse frame after the abandoned one
      if (!abort) begin
         smpRe = '{16384, 0, 0, 0, 0, 0, 0, 0};
         smpIm = '{default: 0};
         exRe = '{default: 2048};
         exIm = '{default: 0};
         exTol = '{default: 0};
         applyStimulus(1'b0, 1'b0, 1'b1);
         if (!abort) waitDrain();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
